// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle CPU control path: opcodes, FSM states,
// and the mux-select codes consumed by the ALU control and datapath.
package multicycle_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_IEXEC  = 4'd11,
        S_IWB    = 4'd12
    } state_t;

endpackage

// File: rtl/multicycle_control_fsm_wait_timer.sv
// Saturating memory-wait counter; expired flags that the wait budget is used up.
module mc_wait_timer #(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned LIMIT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             expired
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && (cnt != '1))
            cnt <= cnt + CNT_W'(1);
    end

    assign expired = (cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle CPU: state register, opcode dispatch,
// per-state datapath control decode and bounded memory-wait handling.
module multicycle_control_fsm
    import multicycle_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned CNT_W          = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OPcode,
    input  logic       mem_ready,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       illegal_op,
    output logic       mem_timeout
);

    state_t             cur_state, nxt_state;
    logic               mem_wait, wait_expired, timed_out;
    logic [CNT_W-1:0]   wait_cnt;
    logic               unused_wait_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cur_state <= S_IDLE;
        else
            cur_state <= nxt_state;
    end

    assign mem_wait  = (cur_state == S_FETCH) || (cur_state == S_MEMRD) || (cur_state == S_MEMWR);
    assign timed_out = mem_wait && !mem_ready && wait_expired;

    mc_wait_timer #(
        .CNT_W (CNT_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (nxt_state != cur_state),
        .en      (mem_wait && !mem_ready),
        .cnt     (wait_cnt),
        .expired (wait_expired)
    );

    // The raw count is kept for debug probing only; decisions use expired.
    assign unused_wait_cnt = ^wait_cnt;

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_IDLE:   nxt_state = S_FETCH;
            S_FETCH:  if (mem_ready) nxt_state = S_DECODE;
                      else if (timed_out) nxt_state = S_IDLE;
            S_DECODE: begin
                case (OPcode)
                    OP_LW, OP_SW:              nxt_state = S_MEMADR;
                    OP_RTYPE:                  nxt_state = S_EXEC;
                    OP_BEQ:                    nxt_state = S_BRANCH;
                    OP_J:                      nxt_state = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI:  nxt_state = S_IEXEC;
                    default:                   nxt_state = S_FETCH;
                endcase
            end
            S_MEMADR: nxt_state = (OPcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) nxt_state = S_MEMWB;
                      else if (timed_out) nxt_state = S_FETCH;
            S_MEMWR:  if (mem_ready || timed_out) nxt_state = S_FETCH;
            S_EXEC:   nxt_state = S_RWB;
            S_IEXEC:  nxt_state = S_IWB;
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_IWB: nxt_state = S_FETCH;
            default:  nxt_state = S_IDLE;
        endcase
    end

    always_comb begin
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_B;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        illegal_op  = 1'b0;
        case (cur_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                // IR load and PC+4 commit only on the cycle memory delivers.
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SH;
                case (OPcode)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J,
                    OP_ADDI, OP_ANDI, OP_ORI: illegal_op = 1'b0;
                    default:                  illegal_op = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_IMM;
            end
            S_IWB: RegWrite = 1'b1;
            default: ;
        endcase
    end

    assign state       = cur_state;
    assign mem_timeout = timed_out;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Table-driven bench for the multicycle control FSM: per-cycle vectors feed a
// scoreboard queue that a negedge checker pops and compares against the DUT.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] OPcode = 6'h00;
    logic       mem_ready = 1'b1;
    logic       IRWrite, PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;
    logic       illegal_op, mem_timeout;

    always #5 clk = ~clk;

    multicycle_control_fsm #(
        .TIMEOUT_CYCLES (15),
        .CNT_W          (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .OPcode      (OPcode),
        .mem_ready   (mem_ready),
        .IRWrite     (IRWrite),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .state       (state),
        .illegal_op  (illegal_op),
        .mem_timeout (mem_timeout)
    );

    typedef struct packed {
        logic       IRWrite, PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
        logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
        logic [1:0] ALUSrcB, ALUOp, PCSource;
        logic [3:0] state;
        logic       illegal_op, mem_timeout;
    } outs_t;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       rdy;
        logic [3:0] st;
        logic       ill;
        logic       tmo;
    } vec_t;

    typedef struct {
        int    idx;
        outs_t exp;
    } sb_t;

    vec_t  vecs[$];
    sb_t   sb[$];
    int    checks = 0;
    int    errors = 0;
    outs_t act;

    assign act = {IRWrite, PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                  state, illegal_op, mem_timeout};

    // Expected control word for one cycle, written from the state table.
    function automatic outs_t model(input vec_t v);
        outs_t o;
        o = '0;
        o.state       = v.st;
        o.illegal_op  = v.ill;
        o.mem_timeout = v.tmo;
        case (v.st)
            4'd1:  begin o.MemRead = 1'b1; o.ALUSrcB = 2'b01; o.IRWrite = v.rdy; o.PCWrite = v.rdy; end
            4'd2:  o.ALUSrcB = 2'b11;
            4'd3:  begin o.ALUSrcA = 1'b1; o.ALUSrcB = 2'b10; end
            4'd4:  begin o.MemRead = 1'b1; o.IorD = 1'b1; end
            4'd5:  begin o.RegWrite = 1'b1; o.MemtoReg = 1'b1; end
            4'd6:  begin o.MemWrite = 1'b1; o.IorD = 1'b1; end
            4'd7:  begin o.ALUSrcA = 1'b1; o.ALUOp = 2'b10; end
            4'd8:  begin o.RegWrite = 1'b1; o.RegDst = 1'b1; end
            4'd9:  begin o.ALUSrcA = 1'b1; o.ALUOp = 2'b01; o.PCWriteCond = 1'b1; o.PCSource = 2'b01; end
            4'd10: begin o.PCWrite = 1'b1; o.PCSource = 2'b10; end
            4'd11: begin o.ALUSrcA = 1'b1; o.ALUSrcB = 2'b10; o.ALUOp = 2'b11; end
            4'd12: o.RegWrite = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    task automatic add(input logic r, input logic [5:0] op, input logic rdy,
                       input logic [3:0] st, input logic ill, input logic tmo);
        vec_t v;
        v.rst = r; v.op = op; v.rdy = rdy; v.st = st; v.ill = ill; v.tmo = tmo;
        vecs.push_back(v);
    endtask

    task automatic rep(input int n, input logic [5:0] op, input logic rdy, input logic [3:0] st);
        for (int i = 0; i < n; i++) add(1'b0, op, rdy, st, 1'b0, 1'b0);
    endtask

    task automatic seq(input logic [5:0] op, input logic [3:0] s0, input logic [3:0] s1,
                       input logic [3:0] s2, input logic [3:0] s3, input int n);
        logic [3:0] s [4];
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int i = 0; i < n; i++) add(1'b0, op, 1'b1, s[i], 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        sb_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL vec%0d state/ctrl: got %h (state %0d) expected %h (state %0d)",
                         e.idx, act, act.state, e.exp, e.exp.state);
            end
        end
    end

    initial begin
        sb_t e;
        // Reset, then idle one cycle.
        add(1'b1, 6'h23, 1'b1, 4'd0, 1'b0, 1'b0);
        add(1'b0, 6'h23, 1'b1, 4'd0, 1'b0, 1'b0);
        // LW: 5 cycles; R-type: 4; BEQ/J: 3.
        seq(6'h23, 4'd1, 4'd2, 4'd3, 4'd4, 4);
        add(1'b0, 6'h23, 1'b1, 4'd5, 1'b0, 1'b0);
        seq(6'h00, 4'd1, 4'd2, 4'd7, 4'd8, 4);
        seq(6'h04, 4'd1, 4'd2, 4'd9, 4'd0, 3);
        seq(6'h02, 4'd1, 4'd2, 4'd10, 4'd0, 3);
        // Unsupported opcode pulses illegal_op in DECODE and refetches.
        add(1'b0, 6'h3F, 1'b1, 4'd1, 1'b0, 1'b0);
        add(1'b0, 6'h3F, 1'b1, 4'd2, 1'b1, 1'b0);
        seq(6'h08, 4'd1, 4'd2, 4'd11, 4'd12, 4);
        seq(6'h0D, 4'd1, 4'd2, 4'd11, 4'd12, 4);
        // FETCH timeout on the 16th waiting cycle, then IDLE.
        rep(15, 6'h2B, 1'b0, 4'd1);
        add(1'b0, 6'h2B, 1'b0, 4'd1, 1'b0, 1'b1);
        add(1'b0, 6'h2B, 1'b0, 4'd0, 1'b0, 1'b0);
        // Ready on the 16th cycle wins over the timeout; then SW with 3 waits.
        rep(15, 6'h2B, 1'b0, 4'd1);
        seq(6'h2B, 4'd1, 4'd2, 4'd3, 4'd0, 3);
        rep(3, 6'h2B, 1'b0, 4'd6);
        add(1'b0, 6'h2B, 1'b1, 4'd6, 1'b0, 1'b0);
        // LW with MEMRD timeout: back to FETCH, never MEMWB.
        seq(6'h23, 4'd1, 4'd2, 4'd3, 4'd0, 3);
        rep(15, 6'h23, 1'b0, 4'd4);
        add(1'b0, 6'h23, 1'b0, 4'd4, 1'b0, 1'b1);
        // Async reset in the middle of a stalled store.
        seq(6'h2B, 4'd1, 4'd2, 4'd3, 4'd0, 3);
        add(1'b0, 6'h2B, 1'b0, 4'd6, 1'b0, 1'b0);
        add(1'b1, 6'h2B, 1'b0, 4'd0, 1'b0, 1'b0);
        add(1'b0, 6'h00, 1'b1, 4'd0, 1'b0, 1'b0);
        seq(6'h00, 4'd1, 4'd2, 4'd7, 4'd8, 4);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            reset     = vecs[i].rst;
            OPcode    = vecs[i].op;
            mem_ready = vecs[i].rdy;
            e.idx = i;
            e.exp = model(vecs[i]);
            sb.push_back(e);
        end

        for (int n = 0; n < 4 && sb.size() > 0; n++) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
